// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, FSM encoding, GF(2^8) S-box and Rcon.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box; shared with the cipher datapath.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    assign y_o = sbox(a_i);

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: one round key per cycle into an 11-entry register file
// with a combinational read port.
module aes_key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] key_in,
    input  logic [3:0]   rk_sel,
    output logic [0:127] rk_out,
    output logic         busy,
    output logic         done,
    output logic         key_valid
);

    state_e       state_q;
    logic [3:0]   rnd_q;
    logic [31:0]  w0_q, w1_q, w2_q, w3_q;
    logic [127:0] rk_q [0:NR];
    logic         busy_q, done_q, valid_q;

    logic [31:0]  rot_w, sub_w, temp_w;
    logic [31:0]  n0_d, n1_d, n2_d, n3_d;
    logic [127:0] rk_new_d;

    assign rot_w = {w3_q[23:0], w3_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .a_i (rot_w[8*b +: 8]),
            .y_o (sub_w[8*b +: 8])
        );
    end

    assign temp_w   = sub_w ^ {rcon(rnd_q), 24'h0};
    assign n0_d     = w0_q ^ temp_w;
    assign n1_d     = w1_q ^ n0_d;
    assign n2_d     = w2_q ^ n1_d;
    assign n3_d     = w3_q ^ n2_d;
    assign rk_new_d = {n0_d, n1_d, n2_d, n3_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rk_q[0] <= key_in;
                        w0_q    <= key_in[0:31];
                        w1_q    <= key_in[32:63];
                        w2_q    <= key_in[64:95];
                        w3_q    <= key_in[96:127];
                        rnd_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= NR; i++) begin
                        if (rnd_q == 4'(i)) rk_q[i] <= rk_new_d;
                    end
                    w0_q <= n0_d;
                    w1_q <= n1_d;
                    w2_q <= n2_d;
                    w3_q <= n3_d;
                    if (rnd_q == 4'(NR)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Indices 11..15 have no storage and read as zero.
    always_comb begin
        rk_out = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_sel == 4'(i)) rk_out = rk_q[i];
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: FIPS-197 vectors, protocol corner cases
// and an end-to-end encryption using the served round keys.
module tb_aes_key_expander;
    import aes_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rk_sel;
    logic [127:0] rk_out;
    logic         busy, done, key_valid;

    aes_key_expander dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .rk_sel    (rk_sel),
        .rk_out    (rk_out),
        .busy      (busy),
        .done      (done),
        .key_valid (key_valid)
    );

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

    typedef struct {
        string        tag;
        logic [3:0]   sel;
        logic [127:0] rk;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected round keys are queued at the moment the key is presented.
    task automatic push_expect(input logic [127:0] key);
        if (key == KEY_A1) begin
            sb.push_back('{"a1_rk0",  4'd0,  KEY_A1});
            sb.push_back('{"a1_rk1",  4'd1,  128'ha0fafe1788542cb123a339392a6c7605});
            sb.push_back('{"a1_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
        end else begin
            sb.push_back('{"seq_rk0",  4'd0,  KEY_SEQ});
            sb.push_back('{"seq_rk1",  4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe});
            sb.push_back('{"seq_rk10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5});
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rk_sel = e.sel;
            #1;
            check(e.tag, rk_out, e.rk);
        end
    endtask

    // Pulses start for one edge; returns right after that edge (E0).
    task automatic pulse_start(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = ~key;
    endtask

    task automatic wait_done(input int budget, output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < budget) begin
            tick();
            edges++;
        end
        if (done !== 1'b1) check("done_timeout", 128'(done), 128'd1);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] rks [11]);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        x = pt ^ rks[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(x[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) x[127-8*i -: 8] = s[i];
            x = x ^ rks[r];
        end
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           edges;
        int           ndone;
        logic [127:0] rks [11];

        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rk_sel = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_valid", 128'(key_valid), 128'd0);
        for (int i = 0; i < 16; i++) begin
            rk_sel = 4'(i);
            #1;
            check($sformatf("rst_rk%0d", i), rk_out, 128'd0);
        end

        // FIPS-197 A.1: done is registered on edge E0+10, i.e. 10 edges after E0.
        push_expect(KEY_A1);
        pulse_start(KEY_A1);
        check("a1_busy_rise", 128'(busy), 128'd1);
        check("a1_valid_low", 128'(key_valid), 128'd0);
        wait_done(20, edges);
        check("a1_done_lat", 128'(edges), 128'd10);
        check("a1_valid_at_done", 128'(key_valid), 128'd1);
        check("a1_busy_fall", 128'(busy), 128'd0);
        drain();
        tick();
        check("a1_done_pulse", 128'(done), 128'd0);

        for (int i = 0; i < 11; i++) begin
            rk_sel = 4'(i);
            #1;
            rks[i] = rk_out;
        end
        check("e2e_cipher", aes_enc(128'h3243f6a8885a308d313198a2e0370734, rks),
              128'h3925841d02dc09fbdc118597196a0b32);

        for (int i = 11; i < 16; i++) begin
            rk_sel = 4'(i);
            #1;
            check($sformatf("oor_rk%0d", i), rk_out, 128'd0);
        end

        // Re-key from IDLE with a valid schedule held.
        push_expect(KEY_SEQ);
        pulse_start(KEY_SEQ);
        check("rekey_valid_drop", 128'(key_valid), 128'd0);
        check("rekey_busy", 128'(busy), 128'd1);
        wait_done(20, edges);
        check("rekey_done_lat", 128'(edges), 128'd10);
        drain();

        // Start while busy: second start with another key at cycle 5 must be ignored.
        push_expect(KEY_A1);
        pulse_start(KEY_A1);
        repeat (4) tick();
        pulse_start(KEY_SEQ);
        wait_done(20, edges);
        check("busy_start_lat", 128'(edges + 5), 128'd10);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        check("busy_start_ndone", 128'(ndone), 128'd1);
        check("busy_start_idle", 128'(busy), 128'd0);
        drain();

        // Reset at cycle 4 of an expansion aborts it with no done.
        pulse_start(KEY_SEQ);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_valid", 128'(key_valid), 128'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        check("abort_ndone", 128'(ndone), 128'd0);
        for (int i = 0; i < 11; i++) begin
            rk_sel = 4'(i);
            #1;
            check($sformatf("abort_rk%0d", i), rk_out, 128'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
